dump_sequencer: RTL and testbench
=================================

DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameter LAST_ADDR, default 16'hFFFF: highest address visited in dump mode; the counter wraps to 0 after it.
REQ-002 Parameter AUTO_DIV, default 250: number of tick strobes between auto-advance steps (about 0.5 s at 500 Hz).
REQ-003 Port clk, input, 1: the single clock for the block.
REQ-004 Port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-005 Port tick, input, 1: one-clk-wide 500 Hz enable strobe.
REQ-006 Port step, input, 1: one-shot step pulse; may be wider than one clk, and only its rising edge counts.
REQ-007 Port dump, input, 1: level; 1 selects dump mode, 0 selects run mode.
REQ-008 Port auto_en, input, 1: level; enables auto-advance in dump mode.
REQ-009 Port risc_addr, input, 16: CPU memory address.
REQ-010 Port ram_dout, input, 16: RAM read data, valid one clk after the address is applied.
REQ-011 Port mem_addr, output, 16: address driven to the RAM.
REQ-012 Port disp_data, output, 32: {mem_addr, captured data} sent to the display controller.
REQ-013 Port dump_active, output, 1: high while the FSM is in any DUMP_* state.
REQ-014 Port wrap, output, 1: one-clk pulse when the counter wraps from LAST_ADDR to 0.

Function
REQ-015 The FSM SHALL have four states: RUN, DUMP_ADDR, DUMP_WAIT and DUMP_SHOW.
REQ-016 In RUN:
- mem_addr SHALL equal risc_addr combinationally.
- disp_data SHALL be {risc_addr, ram_dout}, registered with a 1-clk delay.
REQ-017 RUN SHALL move to DUMP_ADDR on the first clk where dump=1.
REQ-018 In DUMP_*, mem_addr SHALL equal the internal 16-bit counter cnt.
REQ-019 DUMP_ADDR SHALL always move to DUMP_WAIT after 1 clk.
REQ-020 DUMP_WAIT SHALL take 1 clk, then move to DUMP_SHOW, and on that edge latch disp_data <= {cnt, ram_dout}.
REQ-021 Address-to-display latency SHALL be exactly 2 clks.
REQ-022 DUMP_SHOW SHALL hold. On an advance event, cnt SHALL increment and the FSM SHALL return to DUMP_ADDR.
REQ-023 An advance event SHALL be a rising edge of step, or an auto-advance expiry (REQ-030).
REQ-024 If step and auto-advance occur in the same clk, cnt SHALL advance exactly once and the auto timer SHALL restart.
REQ-025 Advance events arriving in DUMP_ADDR or DUMP_WAIT SHALL be discarded; they are not queued.
REQ-026 When cnt == LAST_ADDR and an advance occurs:
- cnt SHALL become 0;
- wrap SHALL pulse for 1 clk.
REQ-027 dump=0 in any DUMP_* state SHALL return the FSM to RUN on the next clk, aborting any pending latch. cnt SHALL be retained, so re-entering dump mode resumes at the same address.
REQ-028 The FSM SHALL never drive the RAM write enable; in dump mode the write path is gated by the top level.

Reset
REQ-029 While reset=0 at a clk edge, the block SHALL set:
- state=RUN, cnt=0, disp_data=0;
- dump_active=0, wrap=0;
- auto timer=0, step edge register=0.
Reset applied mid-dump SHALL take priority over every other event.

Configuration
REQ-030 Macro DUMP_AUTO_EN:
- Defined: the auto timer counts tick strobes while in DUMP_SHOW and auto_en=1. It expires at AUTO_DIV ticks, then clears. It clears on leaving DUMP_SHOW.
- Undefined: no timer logic exists, auto_en is ignored, and only step advances.

Structure
REQ-031 Package dump_pkg SHALL hold:
- the state enum;
- ADDR_W=16 and DATA_W=16;
- the disp_data width constant.
REQ-032 Sub-module auto_timer (tick divider with clear and expire outputs) SHALL be instantiated only under DUMP_AUTO_EN.

Verification
REQ-033 Reset, then dump=0, risc_addr=16'h0040, ram_dout=16'hBEEF -> mem_addr=16'h0040; disp_data=32'h0040BEEF one clk later.
REQ-034 dump=1 with RAM[0]=16'h1234 -> mem_addr=0, dump_active=1, disp_data=32'h00001234 exactly 2 clks after entry.
REQ-035 With LAST_ADDR=16'h0003, apply 4 step pulses -> cnt sequence 1,2,3,0; wrap pulses once, on the 4th step only.
REQ-036 DUMP_AUTO_EN defined, AUTO_DIV=3, auto_en=1, step coincident with the 3rd tick -> cnt advances by exactly 1 and the timer restarts.
REQ-037 dump dropped during DUMP_WAIT at cnt=5, then re-raised -> RUN for at least 1 clk, disp_data not latched, then dump resumes at mem_addr=5.
REQ-038 reset=0 during DUMP_SHOW at cnt=7 -> next clk: state=RUN, cnt=0, disp_data=0.

Source files
------------

// File: rtl/dump_pkg.sv
// dump_pkg: shared state type and widths for the memory dump sequencer.
// Used by dump_sequencer and its auto-advance timer.
package dump_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DISP_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    RUN,
    DUMP_ADDR,
    DUMP_WAIT,
    DUMP_SHOW
  } dump_state_e;

endpackage

// File: rtl/auto_timer.sv
// auto_timer: counts tick strobes while enabled and pulses expire
// on the DIV-th tick; clear holds the count at zero.
module auto_timer #(
  parameter int DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic en,
  input  logic clear,
  output logic expire
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign expire = en & tick & (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (en && tick) begin
      count <= expire ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dump_sequencer.sv
// dump_sequencer: walks RAM addresses and latches {addr, data} for display.
// Defining DUMP_AUTO_EN adds a tick-driven auto-advance timer.
module dump_sequencer
  import dump_pkg::*;
#(
  parameter logic [15:0] LAST_ADDR = 16'hFFFF,
  parameter int          AUTO_DIV  = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        step,
  input  logic        dump,
  input  logic        auto_en,
  input  logic [15:0] risc_addr,
  input  logic [15:0] ram_dout,
  output logic [15:0] mem_addr,
  output logic [31:0] disp_data,
  output logic        dump_active,
  output logic        wrap
);

  dump_state_e state, state_d;

  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [DISP_W-1:0] disp_d;
  logic wrap_d;
  logic step_q;
  logic step_rise;
  logic auto_expire;
  logic advance;

  assign step_rise   = step & ~step_q;
  assign advance     = step_rise | auto_expire;
  assign mem_addr    = (state == RUN) ? risc_addr : cnt;
  assign dump_active = (state != RUN);

`ifdef DUMP_AUTO_EN
  auto_timer #(
    .DIV(AUTO_DIV)
  ) u_auto (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .en     (auto_en & (state == DUMP_SHOW)),
    .clear  (state != DUMP_SHOW),
    .expire (auto_expire)
  );
`else
  logic unused_auto;
  assign unused_auto = auto_en ^ tick ^ (AUTO_DIV == 0);
  assign auto_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      cnt       <= '0;
      disp_data <= '0;
      wrap      <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      disp_data <= disp_d;
      wrap      <= wrap_d;
      step_q    <= step;
    end
  end

  // Dropping dump wins over latching or advancing.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    disp_d  = disp_data;
    wrap_d  = 1'b0;
    unique case (state)
      RUN: begin
        disp_d = {risc_addr, ram_dout};
        if (dump) state_d = DUMP_ADDR;
      end
      DUMP_ADDR: begin
        state_d = dump ? DUMP_WAIT : RUN;
      end
      DUMP_WAIT: begin
        if (!dump) begin
          state_d = RUN;
        end else begin
          state_d = DUMP_SHOW;
          disp_d  = {cnt, ram_dout};
        end
      end
      DUMP_SHOW: begin
        if (!dump) begin
          state_d = RUN;
        end else if (advance) begin
          state_d = DUMP_ADDR;
          if (cnt == LAST_ADDR) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// tb_dump_sequencer: directed bench with a cycle model for two instances
// (LAST_ADDR=3 and default LAST_ADDR), both with AUTO_DIV=3.
module tb_dump_sequencer;

  localparam int TB_DIV = 3;
`ifdef DUMP_AUTO_EN
  localparam bit AUTO_ON = 1'b1;
`else
  localparam bit AUTO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic step = 1'b0;
  logic dump = 1'b0;
  logic auto_en = 1'b0;
  logic [15:0] risc_addr = 16'h0000;

  logic [15:0] ram_o  [2];
  logic [15:0] addr_o [2];
  logic [31:0] disp_o [2];
  logic        act_o  [2];
  logic        wrap_o [2];

  int n_pass = 0;
  int n_total = 0;
  int wrap_seen = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0040) return 16'hBEEF;
    return (a * 16'd3) ^ 16'hC3C3;
  endfunction

  dump_sequencer #(
    .LAST_ADDR(16'h0003),
    .AUTO_DIV (TB_DIV)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .step       (step),
    .dump       (dump),
    .auto_en    (auto_en),
    .risc_addr  (risc_addr),
    .ram_dout   (ram_o[0]),
    .mem_addr   (addr_o[0]),
    .disp_data  (disp_o[0]),
    .dump_active(act_o[0]),
    .wrap       (wrap_o[0])
  );

  dump_sequencer #(
    .AUTO_DIV(TB_DIV)
  ) u_big (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .step       (step),
    .dump       (dump),
    .auto_en    (auto_en),
    .risc_addr  (risc_addr),
    .ram_dout   (ram_o[1]),
    .mem_addr   (addr_o[1]),
    .disp_data  (disp_o[1]),
    .dump_active(act_o[1]),
    .wrap       (wrap_o[1])
  );

  // Synchronous-read RAM seen by each instance.
  always @(posedge clk) begin
    ram_o[0] <= ram_val(addr_o[0]);
    ram_o[1] <= ram_val(addr_o[1]);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: settle counts the clocks until a freshly applied address is shown.
  logic [15:0] m_cnt [2];
  logic [15:0] m_ram [2];
  logic [31:0] m_disp [2];
  bit m_dump [2] = '{1'b0, 1'b0};
  bit m_wrap [2];
  int m_settle [2];
  int m_ticks [2];
  bit m_stq = 1'b0;

  always @(posedge clk) begin
    bit rise;
    bit expire;
    logic [15:0] cur;
    logic [15:0] apre;
    logic [15:0] last;
    rise = step && !m_stq;
    for (int i = 0; i < 2; i++) begin
      last = (i == 0) ? 16'h0003 : 16'hFFFF;
      apre = m_dump[i] ? m_cnt[i] : risc_addr;
      cur = m_ram[i];
      m_ram[i] = ram_val(apre);
      if (!reset) begin
        m_dump[i] = 1'b0;
        m_cnt[i] = 16'h0;
        m_disp[i] = 32'h0;
        m_wrap[i] = 1'b0;
        m_settle[i] = 0;
        m_ticks[i] = 0;
      end else begin
        m_wrap[i] = 1'b0;
        if (!m_dump[i]) begin
          m_disp[i] = {risc_addr, cur};
          m_ticks[i] = 0;
          if (dump) begin
            m_dump[i] = 1'b1;
            m_settle[i] = 2;
          end
        end else if (!dump) begin
          m_dump[i] = 1'b0;
          m_ticks[i] = 0;
        end else if (m_settle[i] > 0) begin
          m_settle[i]--;
          m_ticks[i] = 0;
          if (m_settle[i] == 0) m_disp[i] = {m_cnt[i], cur};
        end else begin
          expire = 1'b0;
          if (AUTO_ON && auto_en && tick) begin
            m_ticks[i]++;
            expire = (m_ticks[i] == TB_DIV);
          end
          if (rise || expire) begin
            if (m_cnt[i] == last) begin
              m_cnt[i] = 16'h0;
              m_wrap[i] = 1'b1;
            end else begin
              m_cnt[i] = m_cnt[i] + 16'h1;
            end
            m_ticks[i] = 0;
            m_settle[i] = 2;
          end
        end
      end
    end
    m_stq = reset ? step : 1'b0;
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.mem_addr", i), 32'(addr_o[i]),
            32'(m_dump[i] ? m_cnt[i] : risc_addr));
        chk($sformatf("u%0d.disp_data", i), disp_o[i], m_disp[i]);
        chk($sformatf("u%0d.dump_active", i), 32'(act_o[i]),
            32'(m_dump[i]));
        chk($sformatf("u%0d.wrap", i), 32'(wrap_o[i]), 32'(m_wrap[i]));
      end
      if (wrap_o[0]) wrap_seen++;
    end
  end

  task automatic pulse_step();
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick_once(input bit st);
    tick = 1'b1;
    step = st;
    @(negedge clk);
    tick = 1'b0;
    step = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected end");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.disp0", disp_o[0], 32'h0);
    chk("rst.disp1", disp_o[1], 32'h0);
    chk("rst.act0", 32'(act_o[0]), 32'h0);
    chk("rst.act1", 32'(act_o[1]), 32'h0);
    chk("rst.wrap0", 32'(wrap_o[0]), 32'h0);
    chk("rst.wrap1", 32'(wrap_o[1]), 32'h0);
    chk_en = 1'b1;

    reset = 1'b1;
    risc_addr = 16'h0040;
    repeat (2) @(negedge clk);
    chk("run.mem_addr", 32'(addr_o[0]), 32'h0040);
    chk("run.disp", disp_o[0], 32'h0040BEEF);

    dump = 1'b1;
    @(negedge clk);
    chk("entry.mem_addr", 32'(addr_o[0]), 32'h0);
    chk("entry.act", 32'(act_o[0]), 32'h1);
    @(negedge clk);
    chk("entry.disp_1clk", disp_o[0], 32'h0040BEEF);
    @(negedge clk);
    chk("entry.disp_2clk", disp_o[0], 32'h00001234);
    chk("entry.disp_2clk_big", disp_o[1], 32'h00001234);

    for (int k = 1; k <= 4; k++) begin
      pulse_step();
      chk($sformatf("step%0d.cnt", k), 32'(addr_o[0]), 32'(k % 4));
      chk($sformatf("step%0d.wraps", k), wrap_seen, (k == 4) ? 1 : 0);
    end
    chk("step.big_cnt", 32'(addr_o[1]), 32'h4);

    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    dump = 1'b0;
    @(negedge clk);
    chk("abort.act", 32'(act_o[1]), 32'h0);
    chk("abort.disp_big", disp_o[1], 32'h0004C3CF);
    chk("abort.disp_small", disp_o[0], 32'h00001234);
    chk("abort.mem_addr", 32'(addr_o[1]), 32'h0040);
    @(negedge clk);
    dump = 1'b1;
    @(negedge clk);
    chk("resume.mem_addr_big", 32'(addr_o[1]), 32'h5);
    chk("resume.mem_addr_small", 32'(addr_o[0]), 32'h1);
    chk("resume.act", 32'(act_o[1]), 32'h1);
    repeat (2) @(negedge clk);
    chk("resume.disp", disp_o[1], 32'h0005C3CC);

    pulse_step();
    pulse_step();
    chk("pre_rst.cnt", 32'(addr_o[1]), 32'h7);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst.act", 32'(act_o[1]), 32'h0);
    chk("mid_rst.disp", disp_o[1], 32'h0);
    chk("mid_rst.mem_addr", 32'(addr_o[1]), 32'h0040);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst.cnt_big", 32'(addr_o[1]), 32'h0);
    chk("post_rst.cnt_small", 32'(addr_o[0]), 32'h0);
    chk("post_rst.act", 32'(act_o[1]), 32'h1);
    repeat (2) @(negedge clk);

    auto_en = 1'b1;
    tick_once(1'b0);
    tick_once(1'b0);
    tick_once(1'b1);
    @(negedge clk);
    chk("coinc.cnt_big", 32'(addr_o[1]), 32'h1);
    chk("coinc.cnt_small", 32'(addr_o[0]), 32'h1);
    tick_once(1'b0);
    tick_once(1'b0);
    chk("restart.cnt", 32'(addr_o[1]), 32'h1);
    tick_once(1'b0);
    chk("auto.cnt", 32'(addr_o[1]), AUTO_ON ? 32'h2 : 32'h1);
    auto_en = 1'b0;
    repeat (2) @(negedge clk);

    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    chk("discard.cnt", 32'(addr_o[1]), AUTO_ON ? 32'h3 : 32'h2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
